memory_arbiter_module: RTL and testbench
========================================

# memory_arbiter_module

Arbitrates the single-port 256x8 RAM between the CPU datapath (MAR address plus MI/MO strobes from the control word) and an external loader/debug port used to program or inspect memory while the machine runs or single-steps. Grants one access per clock, stalls the losing CPU access via `cpu_stall`, supports locked loader bursts, and bounds burst length so neither side starves. Sits between the control/register datapath and `memory_module`.

## Interface
- `ADDR_WIDTH`, 8, address width of the RAM.
- `DATA_WIDTH`, 8, data width of the RAM.
- `HOLD_MAX`, 4, maximum consecutive locked loader beats before one CPU slot is forced (range 1..15).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_ie` / `cpu_oe`  in  1  CPU write (MI) / read (MO) request.
- `cpu_addr`  in  ADDR_WIDTH  CPU address (MAR).
- `cpu_wdata`  in  DATA_WIDTH  CPU write data (bus).
- `cpu_rdata`  out  DATA_WIDTH  read data to bus; 0 when not a granted CPU read.
- `cpu_stall`  out  1  CPU request present but not granted this cycle.
- `ld_req`, `ld_we`, `ld_lock`  in  1  loader request, write select, burst lock.
- `ld_addr` / `ld_wdata`  in  ADDR_WIDTH / DATA_WIDTH  loader address / write data.
- `ld_gnt`  out  1  loader granted this cycle.
- `ld_ack`  out  1  one-cycle completion pulse.
- `ld_rdata`  out  DATA_WIDTH  registered loader read data.
- `mem_ie`, `mem_oe`  out  1  RAM write / read strobes.
- `mem_addr`, `mem_wdata`  out  ADDR_WIDTH / DATA_WIDTH  RAM address / write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data, combinational from `mem_addr`.

## Operation
- CPU request = `cpu_ie | cpu_oe`; both high is treated as write. Loader: `ld_we`=1 write, 0 read.
- Grant (combinational from inputs and registered state), highest priority first:
  1. state LOADER, `ld_req` & `ld_lock`, `beat_cnt` < HOLD_MAX -> loader.
  2. only one side requesting -> that side.
  3. both requesting -> side not holding `last_win`; `last_win` flips to the winner.
- Saturated lock: at `beat_cnt` == HOLD_MAX with CPU requesting, CPU granted one cycle, `beat_cnt` cleared. With no CPU request, the loader continues and `beat_cnt` saturates.
- Granted side drives `mem_addr`, `mem_wdata`, `mem_ie`/`mem_oe`. No grant -> all memory outputs 0.
- States:
  - IDLE: no grant last cycle.
  - CPU: CPU granted last cycle.
  - LOADER: locked loader beat granted last cycle.
  - Any state -> LOADER on a loader grant with `ld_lock`=1 (`beat_cnt` +1; from non-LOADER it loads 1).
  - -> CPU on a CPU grant (`beat_cnt` := 0).
  - -> IDLE on no grant or an unlocked loader grant (`beat_cnt` := 0).
- Reset values: state IDLE, `beat_cnt` 0, `last_win` = loader (CPU wins the first conflict), `ld_ack` 0, `ld_rdata` 0. While `rst`=0, every combinational output is 0 and no RAM write occurs.

## Timing
- Grant, `cpu_stall`, and memory strobes are valid in the same cycle N as the request; the RAM write commits at the rising edge ending N.
- CPU read: `cpu_rdata` = `mem_rdata` in cycle N, with zero added latency. A stalled CPU must hold its request until `cpu_stall`=0.
- Loader: `ld_req` and operands are held until `ld_gnt`=1 and may change after that edge. `ld_ack`=1 in N+1 for exactly one cycle. For reads, `ld_rdata` is captured at the end of N and held until the next loader read.
- Back-to-back loader beats: `ld_gnt` may be high every cycle, with one `ld_ack` per beat, each one cycle later.
- Reset mid-beat: asserting `rst` forces IDLE immediately, suppresses the pending `ld_ack`, and commits no write.

## Test plan
- Reset: `rst`=0 with all requests high -> every output 0; release -> state IDLE, `ld_rdata`=0x00.
- CPU only: `cpu_ie`, addr 0x0F, data 0x2A -> `mem_ie`=1 same cycle, `cpu_stall`=0. Next cycle `cpu_oe` at 0x0F -> `cpu_rdata`=0x2A.
- Loader only: write 0x55 to 0x10 -> `ld_gnt` in N, `ld_ack` in N+1. Read 0x10 -> `ld_ack` with `ld_rdata`=0x55.
- Conflict, no lock: both request continuously after reset -> grants CPU, LD, CPU, LD; `cpu_stall`=1 exactly on the LD cycles.
- Lock, HOLD_MAX=4: `ld_lock`=1 with CPU requesting continuously -> 4 LD, 1 CPU, 4 LD, ...; drop `ld_lock` -> grants alternate.
- Reset mid-burst: `rst` low during a locked write of 0xAA to 0x20 (old value 0x11) -> 0x20 reads 0x11, no `ld_ack`, state IDLE.

Source files
------------

// File: rtl/memory_arbiter_module.sv
// memory_arbiter_module: shares one 256x8 RAM port between the CPU
// datapath and a loader/debug port, with bounded locked loader bursts.
module memory_arbiter_module #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ie,
  input  logic                  cpu_oe,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic                  ld_lock,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_ack,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  mem_ie,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_LOADER
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_MAX);

  state_t     state;
  logic [3:0] beat_cnt;
  logic       last_win;
  logic       cpu_req;
  logic       in_burst;
  logic       gnt_cpu;
  logic       gnt_ld;

  assign cpu_req  = cpu_ie | cpu_oe;
  assign in_burst = (state == S_LOADER) & ld_req & ld_lock;

  // Pick this cycle's winner; nothing is granted while reset is held.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ld  = 1'b0;
    if (rst) begin
      if (in_burst && beat_cnt < HOLD) begin
        gnt_ld = 1'b1;
      end else if (in_burst && cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (cpu_req && ld_req) begin
        gnt_cpu = last_win;
        gnt_ld  = ~last_win;
      end else begin
        gnt_cpu = cpu_req;
        gnt_ld  = ld_req;
      end
    end
  end

  // Route the winner onto the RAM port; both-high CPU strobes mean write.
  always_comb begin
    mem_ie    = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (gnt_cpu) begin
      mem_ie    = cpu_ie;
      mem_oe    = cpu_oe & ~cpu_ie;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (cpu_oe && !cpu_ie) cpu_rdata = mem_rdata;
    end else if (gnt_ld) begin
      mem_ie    = ld_we;
      mem_oe    = ~ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~gnt_cpu & rst;
  assign ld_gnt    = gnt_ld;

  // Burst tracking, fairness bit and loader completion/read capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      beat_cnt <= 4'd0;
      last_win <= 1'b1;
      ld_ack   <= 1'b0;
      ld_rdata <= '0;
    end else begin
      ld_ack <= gnt_ld;
      if (gnt_ld && !ld_we) ld_rdata <= mem_rdata;
      if (cpu_req && ld_req && (gnt_cpu || gnt_ld)) last_win <= gnt_ld;
      if (gnt_ld && ld_lock) begin
        state <= S_LOADER;
        if (state != S_LOADER)   beat_cnt <= 4'd1;
        else if (beat_cnt < HOLD) beat_cnt <= beat_cnt + 4'd1;
      end else if (gnt_cpu) begin
        state    <= S_CPU;
        beat_cnt <= 4'd0;
      end else begin
        state    <= S_IDLE;
        beat_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter_module.sv
// tb_memory_arbiter_module: directed and randomized checks of the RAM
// arbiter against a rule-level reference model and a RAM scoreboard.
module tb_memory_arbiter_module;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_ie, cpu_oe;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       ld_req, ld_we, ld_lock;
  logic [7:0] ld_addr, ld_wdata, ld_rdata;
  logic       ld_gnt, ld_ack;
  logic       mem_ie, mem_oe;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  int       run_len;
  bit       cpu_turn;
  bit       exp_ack;
  bit [7:0] exp_rdata;
  bit       last_gc, last_gl;
  logic       obs_stall, obs_gl, obs_ie, obs_ack;
  logic [7:0] obs_crd, obs_rdata;

  always #5 clk = ~clk;

  memory_arbiter_module #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .HOLD_MAX(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_ie(cpu_ie), .cpu_oe(cpu_oe),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_ie(mem_ie), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) if (mem_ie) ram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_len   = 0;
    cpu_turn  = 1'b1;
    exp_ack   = 1'b0;
    exp_rdata = 8'h00;
    last_gc   = 1'b0;
    last_gl   = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_ie = 0; cpu_oe = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = 0; ld_wdata = 0;
  endtask

  // Called at posedge+1 with inputs applied; returns at next posedge+1.
  task automatic run_cycle();
    bit cr, lr, gc, gl, eie, eoe;
    logic [7:0] ea, ew, ecr;
    #3;
    cr = cpu_ie | cpu_oe;
    lr = ld_req;
    gc = 0;
    gl = 0;
    if (lr && ld_lock && run_len > 0 && run_len < HOLD) gl = 1;
    else if (lr && ld_lock && run_len == HOLD && cr) gc = 1;
    else if (cr && lr) begin
      gc = cpu_turn;
      gl = !cpu_turn;
    end else begin
      gc = cr;
      gl = lr;
    end
    if (cr && lr) cpu_turn = gl;
    ea = 0; ew = 0; eie = 0; eoe = 0; ecr = 0;
    if (gc) begin
      ea = cpu_addr; ew = cpu_wdata;
      eie = cpu_ie; eoe = cpu_oe && !cpu_ie;
      if (eoe) ecr = ref_mem[cpu_addr];
    end else if (gl) begin
      ea = ld_addr; ew = ld_wdata;
      eie = ld_we; eoe = !ld_we;
    end
    chk("cpu_stall", cpu_stall, cr && !gc);
    chk("ld_gnt", ld_gnt, gl);
    chk("mem_ie", mem_ie, eie);
    chk("mem_oe", mem_oe, eoe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("cpu_rdata", cpu_rdata, ecr);
    obs_stall = cpu_stall;
    obs_gl    = ld_gnt;
    obs_ie    = mem_ie;
    obs_crd   = cpu_rdata;
    if (gl && !ld_we) exp_rdata = ref_mem[ld_addr];
    if (eie) ref_mem[ea] = ew;
    exp_ack = gl;
    if (gl && ld_lock) begin
      if (run_len == 0)        run_len = 1;
      else if (run_len < HOLD) run_len = run_len + 1;
    end else begin
      run_len = 0;
    end
    last_gc = gc;
    last_gl = gl;
    @(posedge clk);
    #1;
    chk("ld_ack", ld_ack, exp_ack);
    chk("ld_rdata", ld_rdata, exp_rdata);
    obs_ack   = ld_ack;
    obs_rdata = ld_rdata;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    model_reset();
    rst = 1'b0;
    cpu_ie = 1; cpu_oe = 1; cpu_addr = 8'h33; cpu_wdata = 8'h77;
    ld_req = 1; ld_we = 1; ld_lock = 1; ld_addr = 8'h33; ld_wdata = 8'h66;
    #3;
    chk("rst_mem_ie", mem_ie, 0);
    chk("rst_mem_oe", mem_oe, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_ld_rdata", ld_rdata, 0);
    @(posedge clk);
    #1;
    chk("rst_no_write", ram[8'h33], 8'h00);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // CPU only: write then read back
    cpu_ie = 1; cpu_addr = 8'h0F; cpu_wdata = 8'h2A;
    run_cycle();
    chk("cpu_wr_ie", obs_ie, 1);
    chk("cpu_wr_stall", obs_stall, 0);
    idle_inputs();
    cpu_oe = 1; cpu_addr = 8'h0F;
    run_cycle();
    chk("cpu_rd_data", obs_crd, 8'h2A);

    // Loader only: write then read back
    idle_inputs();
    ld_req = 1; ld_we = 1; ld_addr = 8'h10; ld_wdata = 8'h55;
    run_cycle();
    chk("ld_wr_gnt", obs_gl, 1);
    chk("ld_wr_ack", obs_ack, 1);
    idle_inputs();
    ld_req = 1; ld_addr = 8'h10;
    run_cycle();
    chk("ld_rd_ack", obs_ack, 1);
    chk("ld_rd_data", obs_rdata, 8'h55);
    idle_inputs();
    run_cycle();
    chk("ld_ack_single", obs_ack, 0);

    // Unlocked conflict after a fresh reset: CPU, LD, CPU, LD
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    cpu_oe = 1; cpu_addr = 8'h0F;
    ld_req = 1; ld_we = 0; ld_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("conf_gnt", obs_gl, i % 2);
      chk("conf_stall", obs_stall, i % 2);
    end

    // Locked burst with continuous CPU demand after reset
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    cpu_oe = 1; cpu_addr = 8'h0F;
    ld_req = 1; ld_we = 1; ld_lock = 1;
    for (int i = 0; i < 11; i++) begin
      ld_addr = 8'(8'h40 + i); ld_wdata = 8'(i);
      run_cycle();
      chk("lock_gnt", obs_gl, (i % 5) != 0);
    end
    ld_lock = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("unlock_gnt", obs_gl, (i % 2) == 0);
    end

    // Reset during a locked burst: no write, ack dropped
    idle_inputs();
    ld_req = 1; ld_we = 1; ld_addr = 8'h20; ld_wdata = 8'h11;
    run_cycle();
    idle_inputs();
    ld_req = 1; ld_we = 1; ld_lock = 1; ld_addr = 8'h21; ld_wdata = 8'hAA;
    run_cycle();
    ld_addr = 8'h20;
    #1;
    rst = 1'b0;
    #2;
    chk("mid_ack_cut", ld_ack, 0);
    chk("mid_no_gnt", ld_gnt, 0);
    chk("mid_no_ie", mem_ie, 0);
    @(posedge clk);
    #1;
    chk("mid_ack_none", ld_ack, 0);
    model_reset();
    idle_inputs();
    rst = 1'b1;
    cpu_oe = 1; cpu_addr = 8'h20;
    run_cycle();
    chk("mid_old_data", obs_crd, 8'h11);
    idle_inputs();
    cpu_ie = 1; cpu_addr = 8'h22; cpu_wdata = 8'h01;
    ld_req = 1; ld_we = 1; ld_lock = 1; ld_addr = 8'h23;
    run_cycle();
    chk("mid_idle_cpu_first", obs_gl, 0);

    // Randomized traffic obeying the hold-until-granted rules
    for (int i = 0; i < 400; i++) begin
      if (!((cpu_ie || cpu_oe) && !last_gc)) begin
        case ($urandom_range(0, 4))
          0, 1: begin cpu_ie = 0; cpu_oe = 0; end
          2:    begin cpu_ie = 1; cpu_oe = 0; end
          3:    begin cpu_ie = 0; cpu_oe = 1; end
          default: begin cpu_ie = 1; cpu_oe = 1; end
        endcase
        cpu_addr  = 8'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
      end
      if (!(ld_req && !last_gl)) begin
        ld_req   = $urandom_range(0, 3) != 0;
        ld_we    = $urandom_range(0, 1) != 0;
        ld_lock  = $urandom_range(0, 3) != 0;
        ld_addr  = 8'($urandom_range(0, 7));
        ld_wdata = 8'($urandom);
      end
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
